// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: WIDTH-bit word over valid/ready, sent MSB-first.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sfrm,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-2:0] rest;
  logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  assign din_ready = (state == IDLE);
  assign busy      = ~din_ready;

  // The MSB goes straight to sdo on accept, so only the remaining WIDTH-1 bits are held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rest  <= '0;
      cnt   <= '0;
      sdo   <= 1'b0;
      sfrm  <= 1'b0;
      done  <= 1'b0;
`ifdef PISO_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            rest  <= din[WIDTH-2:0];
            cnt   <= '0;
            sdo   <= din[WIDTH-1];
            sfrm  <= 1'b1;
            state <= SHIFT;
`ifdef PISO_PARITY_EN
            par   <= ^din;
`endif
          end
        end
        SHIFT: begin
          cnt  <= cnt + 1'b1;
          rest <= rest << 1;
          if (cnt == CW'(WIDTH - 1)) begin
`ifdef PISO_PARITY_EN
            sdo   <= par;
            state <= PARITY;
`else
            sdo   <= 1'b0;
            sfrm  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            sdo <= rest[WIDTH-2];
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          sdo   <= 1'b0;
          sfrm  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer against a queue-based frame model.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sdo;
  logic             sfrm;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sdo       (sdo),
    .sfrm      (sfrm),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: queue of bits still to appear on sdo (head is the bit on the wire now).
  bit q[$];
  bit m_done = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
      m_done = (q.size() == 0);
    end else begin
      m_done = 1'b0;
      if (din_valid) begin
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back(din[i]);
`ifdef PISO_PARITY_EN
        q.push_back(^din);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sdo",       {31'd0, sdo},       {31'd0, (q.size() != 0) ? q[0] : 1'b0});
      check("sfrm",      {31'd0, sfrm},      {31'd0, q.size() != 0});
      check("din_ready", {31'd0, din_ready}, {31'd0, q.size() == 0});
      check("busy",      {31'd0, busy},      {31'd0, q.size() != 0});
      check("done",      {31'd0, done},      {31'd0, m_done});
    end
  end

  // Collect each completed frame as an integer, first bit most significant.
  logic [15:0] cap = '0;
  int          cap_n = 0;
  logic [15:0] last = '0;
  int          last_n = 0;

  always @(posedge clk) begin
    if (sfrm) begin
      cap   = {cap[14:0], sdo};
      cap_n = cap_n + 1;
    end else if (done) begin
      last   = cap;
      last_n = cap_n;
      cap    = '0;
      cap_n  = 0;
    end else begin
      cap   = '0;
      cap_n = 0;
    end
  end

  function automatic logic [15:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef PISO_PARITY_EN
    return {7'd0, w, ^w};
`else
    return {8'd0, w};
`endif
  endfunction

  task automatic send(input logic [WIDTH-1:0] w, input string tag);
    bit seen;
    seen = 1'b0;
    din_valid = 1'b1;
    din = w;
    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    check({tag, "_bits"}, {16'd0, last}, {16'd0, frame_of(w)});
    check({tag, "_len"}, last_n, FLEN);
  endtask

  task automatic wait_ready(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * WIDTH; i++) begin
      @(negedge clk);
      if (din_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_ready_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    din_valid = 1'b1;
    din = 8'hFF;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(negedge clk);

    send(8'hA5, "a5");
    send(8'h07, "p07");

    // Back-to-back: second word switched in on the accept edge of the first.
    din_valid = 1'b1;
    din = 8'h3C;
    @(negedge clk);
    din = 8'hFF;
    wait_ready("b2b");
    @(negedge clk);
    din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);

    // New data offered mid-frame must not disturb the word in flight.
    din_valid = 1'b1;
    din = 8'hC3;
    @(negedge clk);
    din = 8'h00;
    wait_ready("stab");
    @(negedge clk);
    din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);

    // Reset while the 4th bit is on sdo.
    din_valid = 1'b1;
    din = 8'hFF;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(8'h81, "r81");

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(63) != 0);
      din_valid = $urandom_range(1);
      din = WIDTH'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    din_valid = 1'b0;
    repeat (FLEN + 3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
